// File: rtl/mul_iter_ctrl.sv
// ----------------------------------------------------------------------------
// mul_iter_ctrl
//
// Area-reduced multiply sequencer for the MDU. One RV M-extension product
// (mul/mulh/mulhsu/mulhu) is built by reusing a single unsigned HxH multiplier
// (H = XLEN/2) over four partial-product passes, followed by one pass that
// turns the unsigned product into the signed/mixed result.
//
// Ports
//   clk      in   clock
//   reset    in   asynchronous active-high reset
//   FlushE   in   synchronous abort of any operation in flight
//   StartE   in   request; taken only when Ready=1 and FlushE=0
//   Funct3E  in   000 mul, 001 mulh, 010 mulhsu, 011/1xx mulhu
//   SrcAE    in   multiplicand
//   SrcBE    in   multiplier
//   Ready    out  combinational; high in IDLE and DONE
//   Busy     out  registered; high while multiplying or correcting
//   Done     out  registered one-cycle pulse; ProdM is valid
//   ProdM    out  full 2*XLEN product, held until the next correction write
// ----------------------------------------------------------------------------
module mul_iter_ctrl #(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                FlushE,
   input  logic                StartE,
   input  logic [2:0]          Funct3E,
   input  logic [XLEN-1:0]     SrcAE,
   input  logic [XLEN-1:0]     SrcBE,
   output logic                Ready,
   output logic                Busy,
   output logic                Done,
   output logic [2*XLEN-1:0]   ProdM
);

   localparam int H = XLEN / 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic                sgnA_q, sgnA_d;
   logic                sgnB_q, sgnB_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                accept;
   logic [H-1:0]        aHalf;
   logic [H-1:0]        bHalf;
   logic [XLEN-1:0]     partial;
   logic [2*XLEN-1:0]   partialExt;
   logic [2*XLEN-1:0]   partialShifted;
   logic [2*XLEN-1:0]   corrA;
   logic [2*XLEN-1:0]   corrB;

   // A request is only taken when the sequencer can accept it and nobody is
   // flushing the stage in the same cycle.
   assign accept = StartE & Ready & ~FlushE;

   // Operand half selection: cnt bit 1 picks the A half, cnt bit 0 the B half,
   // giving lo*lo, lo*hi, hi*lo, hi*hi over the four passes. The two middle
   // passes share the same weight of H bits.
   always_comb begin
      aHalf          = cnt_q[1] ? a_q[XLEN-1:H] : a_q[H-1:0];
      bHalf          = cnt_q[0] ? b_q[XLEN-1:H] : b_q[H-1:0];
      partial        = {{H{1'b0}}, aHalf} * {{H{1'b0}}, bHalf};
      partialExt     = {{XLEN{1'b0}}, partial};
      partialShifted = partialExt;
      case (cnt_q)
         2'd0:    partialShifted = partialExt;
         2'd1,
         2'd2:    partialShifted = partialExt << H;
         default: partialShifted = partialExt << (2 * H);
      endcase
   end

   // Signed correction: the unsigned product of the raw bit patterns differs
   // from the signed product by B<<XLEN when A is negative and by A<<XLEN when
   // B is negative. Everything wraps modulo 2^(2*XLEN).
   always_comb begin
      corrA = sgnA_q ? {b_q, {XLEN{1'b0}}} : '0;
      corrB = sgnB_q ? {a_q, {XLEN{1'b0}}} : '0;
   end

   // State register plus all datapath registers; reset clears everything so
   // the outputs drop immediately on reset without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgnA_q  <= 1'b0;
         sgnB_q  <= 1'b0;
         acc_q   <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgnA_q  <= sgnA_d;
         sgnB_q  <= sgnB_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic. DONE behaves like IDLE for new requests so that
   // back-to-back issues land every six cycles. A flush always wins and
   // returns the sequencer to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = MUL;
         MUL:     if (cnt_q == 2'd3) state_d = CORR;
         CORR:    state_d = DONE;
         DONE:    state_d = accept ? MUL : IDLE;
         default: state_d = IDLE;
      endcase
      if (FlushE) begin
         state_d = IDLE;
      end
   end

   // Datapath next values: latch operands on accept, accumulate partial
   // products while multiplying, and write the corrected result on the
   // correction pass. A flush suppresses the result write and rewinds cnt.
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      sgnA_d = sgnA_q;
      sgnB_d = sgnB_q;
      acc_d  = acc_q;
      prod_d = prod_q;
      if (accept) begin
         a_d    = SrcAE;
         b_d    = SrcBE;
         sgnA_d = SrcAE[XLEN-1] & ((Funct3E == 3'b001) | (Funct3E == 3'b010));
         sgnB_d = SrcBE[XLEN-1] & (Funct3E == 3'b001);
         acc_d  = '0;
         cnt_d  = '0;
      end else if (state_q == MUL) begin
         acc_d = acc_q + partialShifted;
         cnt_d = cnt_q + 2'd1;
      end else if (state_q == CORR) begin
         prod_d = acc_q - corrA - corrB;
      end
      if (FlushE) begin
         cnt_d  = '0;
         prod_d = prod_q;
      end
   end

   // Output logic. Ready is decoded straight from the current state; Busy and
   // Done are registered copies of where the state is heading, so Busy falls
   // in the same cycle Done rises.
   always_comb begin
      Ready  = (state_q == IDLE) || (state_q == DONE);
      busy_d = (state_d == MUL) || (state_d == CORR);
      done_d = (state_d == DONE);
   end

   assign Busy  = busy_q;
   assign Done  = done_q;
   assign ProdM = prod_q;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_iter_ctrl
//
// Self-checking bench for mul_iter_ctrl at XLEN=32. Runs a table of directed
// products, random products against a behavioural model, and hand-written
// flush, back-to-back and reset sequences.
// ----------------------------------------------------------------------------
module tb_mul_iter_ctrl;

   localparam int XLEN = 32;

   logic                clk;
   logic                reset;
   logic                FlushE;
   logic                StartE;
   logic [2:0]          Funct3E;
   logic [XLEN-1:0]     SrcAE;
   logic [XLEN-1:0]     SrcBE;
   logic                Ready;
   logic                Busy;
   logic                Done;
   logic [2*XLEN-1:0]   ProdM;

   int testsRun  = 0;
   int failCount = 0;

   typedef struct {
      string         name;
      logic [2:0]    f3;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [63:0]   expProd;
   } vec_t;

   vec_t vecs[10];
   logic [63:0] expQ[$];

   mul_iter_ctrl #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .FlushE  (FlushE),
      .StartE  (StartE),
      .Funct3E (Funct3E),
      .SrcAE   (SrcAE),
      .SrcBE   (SrcBE),
      .Ready   (Ready),
      .Busy    (Busy),
      .Done    (Done),
      .ProdM   (ProdM)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product: extend each operand to 64 bits according to its
   // signedness for the given funct3 and multiply modulo 2^64.
   function automatic logic [63:0] refProd(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic        signedA;
      logic        signedB;
      logic [63:0] ea;
      logic [63:0] eb;
      signedA = (f3 == 3'b001) || (f3 == 3'b010);
      signedB = (f3 == 3'b001);
      ea = signedA ? {{32{a[31]}}, a} : {32'b0, a};
      eb = signedB ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Wait (bounded) until the sequencer can take a request, then present one
   // operation for exactly one accepting edge. Returns at the negedge of the
   // first busy cycle.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b);
      int waitCycles;
      waitCycles = 0;
      while (!Ready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!Ready) checkOutput("readyTimeout", 64'(Ready), 64'd1);
      Funct3E = f3;
      SrcAE   = a;
      SrcBE   = b;
      StartE  = 1'b1;
      @(negedge clk);
      StartE  = 1'b0;
   endtask

   // Issue one operation and check latency, Busy width, result and the
   // single-cycle Done pulse.
   task automatic runOp(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expected);
      int cycles;
      int busyCycles;
      applyStimulus(f3, a, b);
      cycles     = 1;
      busyCycles = 0;
      while (!Done && cycles < 20) begin
         if (Busy) busyCycles++;
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, ".latency"}, 64'(cycles), 64'd6);
      checkOutput({name, ".busyCycles"}, 64'(busyCycles), 64'd5);
      checkOutput({name, ".prod"}, ProdM, expected);
      checkOutput({name, ".readyAtDone"}, 64'(Ready), 64'd1);
      @(negedge clk);
      checkOutput({name, ".donePulse"}, 64'(Done), 64'd0);
   endtask

   initial begin
      reset   = 1'b1;
      FlushE  = 1'b0;
      StartE  = 1'b0;
      Funct3E = 3'b000;
      SrcAE   = '0;
      SrcBE   = '0;

      vecs[0] = '{"mulhNeg1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
      vecs[1] = '{"mulhuMax",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
      vecs[2] = '{"mulhsuNeg1x2", 3'b010, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE};
      vecs[3] = '{"mulhMinMin",   3'b001, 32'h80000000, 32'h80000000, 64'h4000000000000000};
      vecs[4] = '{"mulhu3x5",     3'b011, 32'h00000003, 32'h00000005, 64'h000000000000000F};
      vecs[5] = '{"mul7x9",       3'b000, 32'h00000007, 32'h00000009, 64'h000000000000003F};
      vecs[6] = '{"f3x100Max",    3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
      vecs[7] = '{"mulMax",       3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
      vecs[8] = '{"mulhsuMinMax", 3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h8000000080000000};
      vecs[9] = '{"mulhPosNeg",   3'b001, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset.prod",  ProdM, 64'd0);
      checkOutput("reset.busy",  64'(Busy), 64'd0);
      checkOutput("reset.done",  64'(Done), 64'd0);
      checkOutput("reset.ready", 64'(Ready), 64'd1);
      reset = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         runOp(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].expProd);
      end

      // Random operations against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] b;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (i % 5 == 0) a[31] = 1'b1;
         if (i % 7 == 0) b[31] = 1'b1;
         runOp($sformatf("rand%0d", i), f3, a, b, refProd(f3, a, b));
      end

      // Flush during cnt2: nothing completes, ProdM keeps the previous result
      runOp("flushPre", 3'b011, 32'd3, 32'd5, 64'hF);
      applyStimulus(3'b000, 32'd7, 32'd9);
      repeat (2) @(negedge clk);
      FlushE = 1'b1;
      @(negedge clk);
      FlushE = 1'b0;
      checkOutput("flushCnt2.busy",  64'(Busy), 64'd0);
      checkOutput("flushCnt2.ready", 64'(Ready), 64'd1);
      checkOutput("flushCnt2.prod",  ProdM, 64'hF);
      begin
         int doneSeen;
         doneSeen = 0;
         repeat (8) begin
            if (Done) doneSeen++;
            @(negedge clk);
         end
         checkOutput("flushCnt2.noDone", 64'(doneSeen), 64'd0);
      end

      // Flush on the correction edge: no write, no Done
      applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (4) @(negedge clk);
      FlushE = 1'b1;
      @(negedge clk);
      FlushE = 1'b0;
      checkOutput("flushCorr.done", 64'(Done), 64'd0);
      checkOutput("flushCorr.prod", ProdM, 64'hF);
      checkOutput("flushCorr.busy", 64'(Busy), 64'd0);

      // Start and flush together: the start is dropped
      Funct3E = 3'b011;
      SrcAE   = 32'd2;
      SrcBE   = 32'd2;
      StartE  = 1'b1;
      FlushE  = 1'b1;
      @(negedge clk);
      StartE  = 1'b0;
      FlushE  = 1'b0;
      checkOutput("startFlush.busy", 64'(Busy), 64'd0);
      repeat (6) @(negedge clk);
      checkOutput("startFlush.prod", ProdM, 64'hF);

      // Start held high with fresh operands every issue
      begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] b;
         int          cyc;
         f3 = 3'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         Funct3E = f3; SrcAE = a; SrcBE = b;
         expQ.push_back(refProd(f3, a, b));
         StartE = 1'b1;
         @(negedge clk);
         for (int k = 0; k < 6; k++) begin
            f3 = 3'($urandom_range(0, 3));
            a = $urandom | 32'h1;
            b = $urandom | 32'h1;
            Funct3E = f3; SrcAE = a; SrcBE = b;
            expQ.push_back(refProd(f3, a, b));
            cyc = 1;
            while (!Done && cyc < 12) begin
               @(negedge clk);
               cyc++;
            end
            checkOutput($sformatf("b2b%0d.interval", k), 64'(cyc), 64'd6);
            checkOutput($sformatf("b2b%0d.prod", k), ProdM, expQ.pop_front());
            @(negedge clk);
         end

         // Asynchronous reset in the middle of a multiply
         @(negedge clk);
         checkOutput("midReset.busyBefore", 64'(Busy), 64'd1);
         #2 reset = 1'b1;
         #1;
         checkOutput("midReset.prod",  ProdM, 64'd0);
         checkOutput("midReset.busy",  64'(Busy), 64'd0);
         checkOutput("midReset.done",  64'(Done), 64'd0);
         checkOutput("midReset.ready", 64'(Ready), 64'd1);
         StartE = 1'b0;
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end

      // Still works after the reset
      runOp("postReset", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
